// File: rtl/midi_sysex_tx.sv
// midi_sysex_tx: reads every synth patch parameter over the controller data bus
// on a dump request. It packs each bank into one sysex message
// (F0 id dev bank data.. csum F7) and shifts the messages out back-to-back as
// MIDI UART on midi_txd.
module midi_sysex_tx #(
    parameter int         CLK_HZ   = 50000000,
    parameter int         BAUD     = 31250,
    parameter logic [7:0] MANUF_ID = 8'h7D,
    parameter int         N_BANKS  = 5,
    parameter int         N_PARAM  = 128
) (
    input  logic               data_clk,
    input  logic               reg_reset_N,
    input  logic               dump_req,
    input  logic [3:0]         midi_ch,
    output logic               rd_en,
    output logic [N_BANKS-1:0] rd_sel,
    output logic [6:0]         rd_adr,
    input  logic [7:0]         rd_data,
    output logic               midi_txd,
    output logic               busy,
    output logic               done
);

    localparam int BIT_CYC = CLK_HZ / BAUD;
    localparam int BCW     = $clog2(BIT_CYC + 1);
    localparam int BKW     = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
    localparam logic [BCW-1:0]     BC_LAST   = BCW'(BIT_CYC - 1);
    localparam logic [6:0]         LAST_ADR  = 7'(N_PARAM - 1);
    localparam logic [BKW-1:0]     LAST_BANK = BKW'(N_BANKS - 1);
    localparam logic [N_BANKS-1:0] SEL_LSB   = N_BANKS'(1);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CSUM, S_EOX, S_DONE} state_t;

    // Two's-complement of the running data sum, reduced to 7 bits.
    function automatic logic [6:0] csum7(input logic [13:0] s);
        return 7'(14'd0 - s);
    endfunction

    state_t             state_q, state_d;
    logic [1:0]         hdr_idx_q, hdr_idx_d;
    logic [BKW-1:0]     bank_q, bank_d;
    logic [6:0]         adr_q, adr_d;
    logic [3:0]         ch_q, ch_d;
    logic [13:0]        sum_q, sum_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               req_q, req_d, have_q, have_d;
    logic [7:0]         dat_q, dat_d;
    logic [1:0]         pipe_q, pipe_d;
    logic               arm_q;
    logic               rd_en_q, rd_en_d;
    logic [N_BANKS-1:0] rd_sel_q, rd_sel_d;
    logic [6:0]         rd_adr_q, rd_adr_d;

    logic               txd_q, act_q;
    logic [8:0]         sh_q;
    logic [3:0]         bit_q;
    logic [BCW-1:0]     baud_q;

    logic               ld_s, tx_free_s;
    logic [7:0]         ld_byte_s;

    // The shifter can take a byte when idle or in the last cycle of a stop bit,
    // which is what makes the inter-byte gap zero.
    assign tx_free_s = !act_q || ((baud_q == {BCW{1'b0}}) && (bit_q == 4'd0));

    // Next-state, byte selection and parameter fetch control.
    always_comb begin
        state_d   = state_q;
        hdr_idx_d = hdr_idx_q;
        bank_d    = bank_q;
        adr_d     = adr_q;
        ch_d      = ch_q;
        sum_d     = sum_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        req_d     = req_q;
        have_d    = have_q;
        dat_d     = dat_q;
        pipe_d    = {pipe_q[0], rd_en_q};
        rd_en_d   = 1'b0;
        rd_sel_d  = {N_BANKS{1'b0}};
        rd_adr_d  = rd_adr_q;
        ld_s      = 1'b0;
        ld_byte_s = 8'h00;
        // Read data is valid two cycles after the strobe.
        if (pipe_q[1]) begin
            have_d = 1'b1;
            dat_d  = rd_data & 8'h7F;
        end else begin
            have_d = have_q;
        end
        case (state_q)
            S_IDLE: begin
                if (dump_req && arm_q) begin
                    state_d   = S_HDR;
                    busy_d    = 1'b1;
                    ch_d      = midi_ch;
                    bank_d    = {BKW{1'b0}};
                    hdr_idx_d = 2'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HDR: begin
                if (tx_free_s) begin
                    ld_s      = 1'b1;
                    hdr_idx_d = hdr_idx_q + 2'd1;
                    case (hdr_idx_q)
                        2'd0: begin
                            ld_byte_s = 8'hF0;
                            sum_d     = 14'd0;
                        end
                        2'd1:    ld_byte_s = MANUF_ID & 8'h7F;
                        2'd2:    ld_byte_s = {4'h0, ch_q};
                        default: ld_byte_s = {1'b0, 7'(bank_q)};
                    endcase
                    if (hdr_idx_q == 2'd3) begin
                        state_d = S_DATA;
                        adr_d   = 7'd0;
                        req_d   = 1'b0;
                    end else begin
                        state_d = S_HDR;
                    end
                end else begin
                    state_d = S_HDR;
                end
            end
            S_DATA: begin
                if (tx_free_s && have_q) begin
                    ld_s      = 1'b1;
                    ld_byte_s = dat_q;
                    sum_d     = sum_q + {6'd0, dat_q};
                    have_d    = 1'b0;
                    req_d     = 1'b0;
                    adr_d     = adr_q + 7'd1;
                    if (adr_q == LAST_ADR) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end else if (!req_q) begin
                    // Fetch the next parameter while the current byte shifts out.
                    rd_en_d  = 1'b1;
                    rd_sel_d = SEL_LSB << bank_q;
                    rd_adr_d = adr_q;
                    req_d    = 1'b1;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CSUM: begin
                if (tx_free_s) begin
                    ld_s      = 1'b1;
                    ld_byte_s = {1'b0, csum7(sum_q)};
                    state_d   = S_EOX;
                end else begin
                    state_d = S_CSUM;
                end
            end
            S_EOX: begin
                if (tx_free_s) begin
                    ld_s      = 1'b1;
                    ld_byte_s = 8'hF7;
                    if (bank_q == LAST_BANK) begin
                        state_d = S_DONE;
                    end else begin
                        bank_d    = bank_q + {{(BKW-1){1'b0}}, 1'b1};
                        hdr_idx_d = 2'd0;
                        state_d   = S_HDR;
                    end
                end else begin
                    state_d = S_EOX;
                end
            end
            S_DONE: begin
                // Busy drops the cycle after the final stop bit ends.
                if (tx_free_s) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control state registers; arm_q blocks a request on the reset release edge.
    always_ff @(posedge data_clk or negedge reg_reset_N) begin
        if (!reg_reset_N) begin
            state_q   <= S_IDLE;
            hdr_idx_q <= 2'd0;
            bank_q    <= {BKW{1'b0}};
            adr_q     <= 7'd0;
            ch_q      <= 4'd0;
            sum_q     <= 14'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            req_q     <= 1'b0;
            have_q    <= 1'b0;
            dat_q     <= 8'h00;
            pipe_q    <= 2'd0;
            arm_q     <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_sel_q  <= {N_BANKS{1'b0}};
            rd_adr_q  <= 7'd0;
        end else begin
            state_q   <= state_d;
            hdr_idx_q <= hdr_idx_d;
            bank_q    <= bank_d;
            adr_q     <= adr_d;
            ch_q      <= ch_d;
            sum_q     <= sum_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            req_q     <= req_d;
            have_q    <= have_d;
            dat_q     <= dat_d;
            pipe_q    <= pipe_d;
            arm_q     <= 1'b1;
            rd_en_q   <= rd_en_d;
            rd_sel_q  <= rd_sel_d;
            rd_adr_q  <= rd_adr_d;
        end
    end

    // UART shifter: start bit on load, then 8 data bits LSB first and a stop bit.
    always_ff @(posedge data_clk or negedge reg_reset_N) begin
        if (!reg_reset_N) begin
            txd_q  <= 1'b1;
            act_q  <= 1'b0;
            sh_q   <= 9'h1FF;
            bit_q  <= 4'd0;
            baud_q <= {BCW{1'b0}};
        end else if (ld_s) begin
            txd_q  <= 1'b0;
            act_q  <= 1'b1;
            sh_q   <= {1'b1, ld_byte_s};
            bit_q  <= 4'd9;
            baud_q <= BC_LAST;
        end else if (act_q) begin
            if (baud_q == {BCW{1'b0}}) begin
                if (bit_q == 4'd0) begin
                    act_q <= 1'b0;
                    txd_q <= 1'b1;
                end else begin
                    txd_q  <= sh_q[0];
                    sh_q   <= {1'b1, sh_q[8:1]};
                    bit_q  <= bit_q - 4'd1;
                    baud_q <= BC_LAST;
                end
            end else begin
                baud_q <= baud_q - {{(BCW-1){1'b0}}, 1'b1};
            end
        end else begin
            txd_q <= 1'b1;
        end
    end

    assign midi_txd = txd_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_en    = rd_en_q;
    assign rd_sel   = rd_sel_q;
    assign rd_adr   = rd_adr_q;

endmodule

// File: tb/tb_midi_sysex_tx.sv
// Directed bench for midi_sysex_tx: three instances (4-param, 2-param and
// full 5x128 dumps). The serial line is decoded cycle by cycle and compared
// against hand-computed byte streams.
module tb_midi_sysex_tx;

    logic       data_clk = 1'b0;
    logic       reg_reset_N;
    logic [3:0] midi_ch;
    logic       dump_req_a, dump_req_b, dump_req_c;

    logic       rd_en_a, rd_en_b, rd_en_c;
    logic [0:0] rd_sel_a, rd_sel_b;
    logic [4:0] rd_sel_c;
    logic [6:0] rd_adr_a, rd_adr_b, rd_adr_c;
    logic [7:0] rd_data_a, rd_data_b, rd_data_c;
    logic       txd_a, txd_b, txd_c, busy_a, busy_b, busy_c, done_a, done_b, done_c;

    int n_chk = 0, n_pass = 0;
    int sel = 0;
    logic txd_m, busy_m, done_m;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    always #5 data_clk = ~data_clk;

    midi_sysex_tx #(.CLK_HZ(500000), .N_BANKS(1), .N_PARAM(4)) u_a (
        .data_clk(data_clk), .reg_reset_N(reg_reset_N), .dump_req(dump_req_a), .midi_ch(midi_ch),
        .rd_en(rd_en_a), .rd_sel(rd_sel_a), .rd_adr(rd_adr_a), .rd_data(rd_data_a),
        .midi_txd(txd_a), .busy(busy_a), .done(done_a));
    midi_sysex_tx #(.CLK_HZ(500000), .N_BANKS(1), .N_PARAM(2)) u_b (
        .data_clk(data_clk), .reg_reset_N(reg_reset_N), .dump_req(dump_req_b), .midi_ch(midi_ch),
        .rd_en(rd_en_b), .rd_sel(rd_sel_b), .rd_adr(rd_adr_b), .rd_data(rd_data_b),
        .midi_txd(txd_b), .busy(busy_b), .done(done_b));
    midi_sysex_tx #(.CLK_HZ(125000), .N_BANKS(5), .N_PARAM(128)) u_c (
        .data_clk(data_clk), .reg_reset_N(reg_reset_N), .dump_req(dump_req_c), .midi_ch(midi_ch),
        .rd_en(rd_en_c), .rd_sel(rd_sel_c), .rd_adr(rd_adr_c), .rd_data(rd_data_c),
        .midi_txd(txd_c), .busy(busy_c), .done(done_c));

    function automatic int sel2idx(input logic [4:0] s);
        int idx = 0;
        for (int i = 0; i < 5; i++) if (s[i]) idx = i;
        return idx;
    endfunction

    function automatic logic [7:0] cval(input int b, input logic [6:0] a);
        return 8'(int'(a) * 3 + b * 17 + 64);
    endfunction

    // Parameter bus models: data appears exactly two cycles after rd_en,
    // with a filler value in every other cycle.
    logic       va1, va2, vb1, vb2, vc1, vc2;
    logic [6:0] aa1, aa2, ac1, ac2;
    int         bc1, bc2;
    always @(posedge data_clk) begin
        va1 <= rd_en_a; aa1 <= rd_adr_a; va2 <= va1; aa2 <= aa1;
        vb1 <= rd_en_b; vb2 <= vb1;
        vc1 <= rd_en_c; ac1 <= rd_adr_c; bc1 <= sel2idx(rd_sel_c);
        vc2 <= vc1; ac2 <= ac1; bc2 <= bc1;
    end
    assign rd_data_a = va2 ? ({1'b0, aa2} + 8'd1) : 8'hAA;
    assign rd_data_b = vb2 ? 8'hFF : 8'h00;
    assign rd_data_c = vc2 ? cval(bc2, ac2) : 8'h55;

    // Event counters, compared as before/after differences.
    int rdc_a = 0, rdc_b = 0, rdc_c = 0, dn_a = 0, dn_b = 0, dn_c = 0, selbad = 0;
    int bank_cnt[5] = '{0, 0, 0, 0, 0};
    always @(posedge data_clk) begin
        if (rd_en_a) begin
            rdc_a <= rdc_a + 1;
            if (rd_sel_a != 1'b1) selbad <= selbad + 1;
        end
        if (rd_en_b) begin
            rdc_b <= rdc_b + 1;
            if (rd_sel_b != 1'b1) selbad <= selbad + 1;
        end
        if (rd_en_c) begin
            rdc_c <= rdc_c + 1;
            if (!$onehot(rd_sel_c)) selbad <= selbad + 1;
            bank_cnt[sel2idx(rd_sel_c)] <= bank_cnt[sel2idx(rd_sel_c)] + 1;
        end
        if (done_a) dn_a <= dn_a + 1;
        if (done_b) dn_b <= dn_b + 1;
        if (done_c) dn_c <= dn_c + 1;
    end

    always_comb begin
        case (sel)
            0:       begin txd_m = txd_a; busy_m = busy_a; done_m = done_a; end
            1:       begin txd_m = txd_b; busy_m = busy_b; done_m = done_b; end
            default: begin txd_m = txd_c; busy_m = busy_c; done_m = done_c; end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_req(input int s, input logic v);
        case (s)
            0:       dump_req_a = v;
            1:       dump_req_b = v;
            default: dump_req_c = v;
        endcase
    endtask

    // Pulse dump_req for one cycle (cycle T); checks busy at T+1 and start bit at T+2.
    task automatic kick(input int s, input string tag);
        sel = s;
        @(negedge data_clk); set_req(s, 1'b1);
        @(negedge data_clk); set_req(s, 1'b0);
        chk({tag, " busy@T+1"}, busy_m, 1);
        chk({tag, " idle@T+1"}, txd_m, 1);
        @(negedge data_clk);
        chk({tag, " start@T+2"}, txd_m, 0);
    endtask

    // Decode exp_q.size() frames starting at the current negedge (first start-bit
    // cycle). Every bit must hold for exactly bc cycles and frames must abut.
    task automatic rx_stream(input int bc, input string tag);
        int nb;
        logic [9:0] fr;
        logic stable, busy_end;
        nb = exp_q.size();
        rx_q.delete();
        busy_end = 1'b0;
        for (int k = 0; k < nb; k++) begin
            stable = 1'b1;
            for (int i = 0; i < 10; i++) begin
                fr[i] = txd_m;
                for (int j = 1; j < bc; j++) begin
                    @(negedge data_clk);
                    if (txd_m !== fr[i]) stable = 1'b0;
                end
                if (k == nb - 1 && i == 9) busy_end = busy_m;
                @(negedge data_clk);
            end
            rx_q.push_back(fr[8:1]);
            chk($sformatf("%s byte%0d", tag, k), fr[8:1], exp_q[k]);
            chk($sformatf("%s frame%0d", tag, k), {stable, fr[0], fr[9]}, 3'b101);
        end
        chk({tag, " busy in last stop"}, busy_end, 1);
        chk({tag, " busy fell"}, busy_m, 0);
        chk({tag, " done pulse"}, done_m, 1);
    endtask

    initial begin
        int r0, d0, s0, sum;
        logic msb;
        reg_reset_N = 1'b0;
        dump_req_a = 1'b0; dump_req_b = 1'b0; dump_req_c = 1'b0;
        midi_ch = 4'd3;
        repeat (3) @(negedge data_clk);
        chk("rst txd", txd_a, 1);
        chk("rst busy", busy_a, 0);
        chk("rst done", done_a, 0);
        chk("rst rd_en", rd_en_c, 0);
        chk("rst rd_sel", rd_sel_c, 0);
        chk("rst rd_adr", rd_adr_c, 0);
        reg_reset_N = 1'b1;
        repeat (2) @(negedge data_clk);

        // Reset during data bit 2 of F0 (that bit is 0).
        kick(0, "A0");
        repeat (50) @(negedge data_clk);
        chk("A0 bit2 low", txd_a, 0);
        #2 reg_reset_N = 1'b0;
        #1;
        chk("async rst txd", txd_a, 1);
        chk("async rst busy", busy_a, 0);
        // A request on the reset release edge must be ignored.
        @(negedge data_clk); dump_req_a = 1'b1;
        @(posedge data_clk); reg_reset_N = 1'b1;
        @(negedge data_clk); dump_req_a = 1'b0;
        chk("release req busy", busy_a, 0);
        repeat (3) @(negedge data_clk);
        chk("release req txd", txd_a, 1);
        chk("release req busy2", busy_a, 0);

        // Single bank, N_PARAM=4, rd_data=addr+1.
        exp_q = '{8'hF0, 8'h7D, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h76, 8'hF7};
        r0 = rdc_a; d0 = dn_a;
        kick(0, "A");
        rx_stream(16, "A");
        @(negedge data_clk);
        chk("A rd_en count", rdc_a - r0, 4);
        chk("A done count", dn_a - d0, 1);

        // Masking and checksum: both parameters read as FF.
        exp_q = '{8'hF0, 8'h7D, 8'h03, 8'h00, 8'h7F, 8'h7F, 8'h02, 8'hF7};
        r0 = rdc_b;
        kick(1, "B");
        rx_stream(16, "B");
        msb = 1'b0;
        for (int k = 1; k < rx_q.size() - 1; k++) msb = msb | rx_q[k][7];
        chk("B msb clear", msb, 0);
        chk("B rd_en count", rdc_b - r0, 2);

        // Five banks of 128, with a second request and a channel change mid-dump.
        midi_ch = 4'd5;
        exp_q.delete();
        for (int b = 0; b < 5; b++) begin
            exp_q.push_back(8'hF0); exp_q.push_back(8'h7D);
            exp_q.push_back(8'h05); exp_q.push_back(8'(b));
            sum = 0;
            for (int a = 0; a < 128; a++) begin
                exp_q.push_back(cval(b, 7'(a)) & 8'h7F);
                sum = sum + int'(cval(b, 7'(a)) & 8'h7F);
            end
            exp_q.push_back(8'((128 - (sum % 128)) % 128));
            exp_q.push_back(8'hF7);
        end
        r0 = rdc_c; d0 = dn_c; s0 = selbad;
        fork
            begin
                kick(2, "C");
                rx_stream(4, "C");
            end
            begin
                repeat (100) @(negedge data_clk);
                dump_req_c = 1'b1;
                midi_ch = 4'd9;
                @(negedge data_clk);
                dump_req_c = 1'b0;
            end
        join
        chk("C rd_en count", rdc_c - r0, 640);
        chk("rd_sel onehot", selbad - s0, 0);
        for (int b = 0; b < 5; b++) chk($sformatf("C bank%0d reads", b), bank_cnt[b], 128);
        repeat (50) @(negedge data_clk);
        chk("C single dump busy", busy_c, 0);
        chk("C single dump txd", txd_c, 1);
        chk("C done count", dn_c - d0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
